seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial sequence detector, the successor to the fixed-pattern single-bit detector. Pattern and pattern length are loaded at runtime, up to PAT_W bits. Overlapping or non-overlapping match counting is selectable. A per-bit valid qualifier and a saturating match counter are included. It sits on a serial bit stream and flags every occurrence of the loaded pattern.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=1)
CNT_W, 8, width of match counter
IDX_W, 16, width of bit-position counter (used only with optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
en  input  1  bit-valid qualifier; in sampled only when en=1
in  input  1  serial data bit
load  input  1  latch pat/pat_len/overlap, restart detection
pat  input  PAT_W  pattern; pat[pat_len-1] = first bit received, pat[0] = last
pat_len  input  $clog2(PAT_W)+1  pattern length, valid 1..PAT_W
overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
clr_cnt  input  1  clear match counter
out  output  1  one-cycle match pulse
state  output  2  00 IDLE, 01 FILL, 10 HUNT
match_cnt  output  CNT_W  saturating count of matches
cnt_sat  output  1  high while match_cnt = all ones

Behaviour:
- Reset (rst=0 at edge): state=IDLE, pat_r=0, len_r=0, ovl_r=0, hist=0, fill=0, out=0, match_cnt=0, cnt_sat=0. Reset overrides all other inputs.
- IDLE: no pattern loaded. in/en ignored, out=0. Leaves IDLE only on a valid load.
- Valid load (load=1, 1<=pat_len<=PAT_W), accepted in any state:
  - latch pat, pat_len, overlap
  - hist<=0, fill<=0, state<=FILL
  - match_cnt unchanged
  - an en bit in the same cycle is dropped
- Invalid load (pat_len=0 or >PAT_W): ignored entirely, no state change. An en bit that cycle is processed normally.
- Accepted bit (en=1, no valid load): hist <= {hist[PAT_W-2:0], in}. fill counts accepted bits since restart and saturates at len_r.
- Match condition, evaluated at the edge on the new window {hist,in}:
  - fill+1 >= len_r, and
  - low len_r bits of {hist,in} equal pat_r[len_r-1:0]
  - bits of pat above len_r are don't-care
- out is registered: high for exactly the one cycle following the edge that sampled the completing bit, otherwise 0. The same applies when en=0.
- After a match:
  - overlap=1: fill stays saturated, detection continues on the existing history
  - overlap=0: fill<=0 and hist<=0, so the next match needs len_r fresh bits
- state: FILL while fill<len_r, HUNT when fill=len_r. len_r=1 can match straight from FILL.
- match_cnt:
  - +1 per match, holds at 2^CNT_W-1
  - cnt_sat = (match_cnt == all ones)
  - clr_cnt without a match: count becomes 0
  - clr_cnt and a match in the same cycle: count becomes 1
- en=0: hist, fill and state hold.
- Reset mid-stream: all progress discarded, back to IDLE; a new load is required.

Optional Feature:
SEQ_MATCH_POS_EN
- Defined:
  - adds IDX_W-bit internal bit_idx, counting accepted bits since the last valid load; wraps modulo 2^IDX_W
  - reset and load set bit_idx to 0
  - adds output port match_pos (IDX_W), reset 0
  - on each match, match_pos captures the 0-based index of the completing bit and updates in the same cycle out rises; it holds otherwise
- Undefined: no bit_idx and no match_pos port; all other behaviour is identical.

Test Plan:
1. Reset, then load pat=8'h07, pat_len=3, overlap=1. Stream 16'b0110010111011110 LSB first, en=1 each bit -> out pulses after bits 3, 4 and 8; match_cnt=3; match_pos=3,4,8 (with SEQ_MATCH_POS_EN).
2. Same stream with overlap=0 -> out after bits 3 and 8 only; match_cnt=2.
3. Load pat=8'h0B, pat_len=4 (1,0,1,1). Same stream -> single pulse after bit 7; state reads FILL for the first 3 bits, then HUNT.
4. CNT_W=2, pat_len=1, pat=1, five 1-bits -> match_cnt 1,2,3,3,3; cnt_sat=1 from the 3rd match. Then clr_cnt together with a match -> match_cnt=1, cnt_sat=0.
5. Load with pat_len=0 while in HUNT -> state, pat_r and len_r unchanged, detection continues. Load arriving together with en=1 -> that bit is dropped, fill=0.
6. Mid-pattern (after 1,1 of "111"): rst=0 for 1 cycle -> state=IDLE, out=0, match_cnt=0. Following bits produce no pulses until a new load.

Source files
------------

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with overlap select, bit-valid qualifier and saturating match count; SEQ_MATCH_POS_EN adds match_pos.
// Latency: out, match_cnt and match_pos update one cycle after the edge that samples the completing bit.
// Backpressure: none; en qualifies each bit, and a valid load restarts detection and drops that cycle's bit.
module seq_detect_param #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int IDX_W = 16,
   localparam int LW = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in,
   input  logic             load,
   input  logic [PAT_W-1:0] pat,
   input  logic [LW-1:0]    pat_len,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             out,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] match_cnt,
`ifdef SEQ_MATCH_POS_EN
   output logic [IDX_W-1:0] match_pos,
`endif
   output logic             cnt_sat
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      HUNT = 2'b10
   } state_t;

   // The oldest history bit never reaches the compare window, so it is not stored.
   localparam int HW = (PAT_W > 1) ? PAT_W - 1 : 1;

   state_t           st;
   logic [PAT_W-1:0] pat_r;
   logic [HW-1:0]    hist;
   logic [LW-1:0]    len_r;
   logic [LW-1:0]    fill;
   logic             ovl_r;

   logic [PAT_W-1:0] win;
   logic [LW:0]      fill_inc;
   logic [LW-1:0]    fill_nxt;
   logic             load_ok;
   logic             take;
   logic             eq;
   logic             hit;

   generate
      if (PAT_W > 1) begin : g_win
         assign win = {hist, in};
      end else begin : g_win1
         assign win = in;
      end
   endgenerate

   always_comb begin
      load_ok  = load && (pat_len != '0) && (int'(pat_len) <= PAT_W);
      take     = en && !load_ok && (st != IDLE);
      fill_inc = {1'b0, fill} + 1'b1;
      fill_nxt = (fill_inc >= {1'b0, len_r}) ? len_r : fill_inc[LW-1:0];
      eq       = 1'b1;
      for (int i = 0; i < PAT_W; i++) begin
         if ((i < int'(len_r)) && (win[i] != pat_r[i])) eq = 1'b0;
      end
      hit = take && (fill_inc >= {1'b0, len_r}) && eq;
   end

`ifdef SEQ_MATCH_POS_EN
   logic [IDX_W-1:0] bit_idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_idx   <= '0;
         match_pos <= '0;
      end else if (load_ok) begin
         bit_idx <= '0;
      end else if (take) begin
         bit_idx <= bit_idx + 1'b1;
         if (hit) match_pos <= bit_idx;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         st        <= IDLE;
         pat_r     <= '0;
         len_r     <= '0;
         ovl_r     <= 1'b0;
         hist      <= '0;
         fill      <= '0;
         out       <= 1'b0;
         match_cnt <= '0;
      end else begin
         out <= hit;
         // A clear coinciding with a match counts that match as the first.
         if (hit) begin
            if (clr_cnt)         match_cnt <= CNT_W'(1);
            else if (!cnt_sat)   match_cnt <= match_cnt + 1'b1;
         end else if (clr_cnt) begin
            match_cnt <= '0;
         end

         if (load_ok) begin
            pat_r <= pat;
            len_r <= pat_len;
            ovl_r <= overlap;
            hist  <= '0;
            fill  <= '0;
            st    <= FILL;
         end else if (take) begin
            if (hit && !ovl_r) begin
               hist <= '0;
               fill <= '0;
               st   <= FILL;
            end else begin
               hist <= win[HW-1:0];
               fill <= fill_nxt;
               st   <= (fill_nxt == len_r) ? HUNT : FILL;
            end
         end
      end
   end

   assign state   = st;
   assign cnt_sat = &match_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a CNT_W=2 instance sharing the same stimulus.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       in = 1'b0;
   logic       load = 1'b0;
   logic [7:0] pat = '0;
   logic [3:0] pat_len = '0;
   logic       overlap = 1'b0;
   logic       clr_cnt = 1'b0;

   logic       out_a, sat_a, out_b, sat_b;
   logic [1:0] state_a, state_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
`ifdef SEQ_MATCH_POS_EN
   logic [15:0] pos_a, pos_b;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] stream = 16'b0110010111011110;
   logic [15:0] m1 = 16'h0118;
   logic [15:0] m2 = 16'h0108;
   logic [15:0] m3 = 16'h0080;

   always #5 clk = ~clk;

   seq_detect_param dut_a (
      .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat(pat),
      .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
      .out(out_a), .state(state_a), .match_cnt(cnt_a),
`ifdef SEQ_MATCH_POS_EN
      .match_pos(pos_a),
`endif
      .cnt_sat(sat_a)
   );

   seq_detect_param #(.CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat(pat),
      .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
      .out(out_b), .state(state_b), .match_cnt(cnt_b),
`ifdef SEQ_MATCH_POS_EN
      .match_pos(pos_b),
`endif
      .cnt_sat(sat_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      en = 1'b1;
      in = b;
      tick();
      en = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
      load = 1'b1;
      pat = p;
      pat_len = l;
      overlap = o;
      tick();
      load = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
   endtask

   initial begin
      // reset
      tick();
      tick();
      check("rst_state", state_a, 2'b00);
      check("rst_out", out_a, 1'b0);
      check("rst_cnt", cnt_a, 8'd0);
      check("rst_sat", sat_a, 1'b0);
`ifdef SEQ_MATCH_POS_EN
      check("rst_pos", pos_a, 16'd0);
`endif
      rst = 1'b1;
      send(1'b1);
      check("idle_ignores", out_a, 1'b0);
      check("idle_state", state_a, 2'b00);

      // 1: "111" overlapping
      do_load(8'h07, 4'd3, 1'b1);
      check("t1_load_state", state_a, 2'b01);
      for (int i = 0; i < 16; i++) begin
         send(stream[i]);
         check($sformatf("t1_out%0d", i), out_a, m1[i]);
`ifdef SEQ_MATCH_POS_EN
         if (m1[i]) check($sformatf("t1_pos%0d", i), pos_a, i);
`endif
      end
      check("t1_cnt", cnt_a, 8'd3);

      // 2: same, non-overlapping
      pulse_clr();
      check("t2_clr", cnt_a, 8'd0);
      do_load(8'h07, 4'd3, 1'b0);
      for (int i = 0; i < 16; i++) begin
         send(stream[i]);
         check($sformatf("t2_out%0d", i), out_a, m2[i]);
      end
      check("t2_cnt", cnt_a, 8'd2);

      // 3: "1011", upper pattern bits don't-care
      do_load(8'hFB, 4'd4, 1'b1);
      for (int i = 0; i < 16; i++) begin
         send(stream[i]);
         check($sformatf("t3_out%0d", i), out_a, m3[i]);
         check($sformatf("t3_state%0d", i), state_a, (i < 3) ? 2'b01 : 2'b10);
`ifdef SEQ_MATCH_POS_EN
         if (m3[i]) check("t3_pos", pos_a, 16'd7);
`endif
      end
      check("t3_cnt", cnt_a, 8'd3);

      // 4: saturation on the 2-bit counter
      pulse_clr();
      do_load(8'h01, 4'd1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         send(1'b1);
         check($sformatf("t4_out%0d", k), out_b, 1'b1);
         check($sformatf("t4_cnt%0d", k), cnt_b, (k < 2) ? k + 1 : 3);
         check($sformatf("t4_sat%0d", k), sat_b, (k >= 2) ? 1'b1 : 1'b0);
      end
      clr_cnt = 1'b1;
      send(1'b1);
      clr_cnt = 1'b0;
      check("t4_clr_hit_cnt", cnt_b, 2'd1);
      check("t4_clr_hit_sat", sat_b, 1'b0);

      // 5: invalid loads ignored, bit processed
      check("t5_pre_state", state_a, 2'b10);
      load = 1'b1; pat = 8'hFE; pat_len = 4'd0; overlap = 1'b0; en = 1'b1; in = 1'b1;
      tick();
      load = 1'b0; en = 1'b0;
      check("t5_len0_out", out_a, 1'b1);
      check("t5_len0_state", state_a, 2'b10);
      load = 1'b1; pat_len = 4'd9; en = 1'b1; in = 1'b0;
      tick();
      load = 1'b0; en = 1'b0;
      check("t5_len9_out", out_a, 1'b0);
      check("t5_len9_state", state_a, 2'b10);
      send(1'b1);
      check("t5_still_hunting", out_a, 1'b1);
      check("t5_ovl_kept", state_a, 2'b10);
      // valid load drops the coincident bit
      load = 1'b1; pat = 8'h07; pat_len = 4'd3; overlap = 1'b1; en = 1'b1; in = 1'b1;
      tick();
      load = 1'b0; en = 1'b0;
      check("t5_drop_state", state_a, 2'b01);
      check("t5_drop_out", out_a, 1'b0);
      send(1'b1);
      check("t5_b1_out", out_a, 1'b0);
      in = 1'b1;
      tick();
      check("t5_hold_out", out_a, 1'b0);
      check("t5_hold_state", state_a, 2'b01);
      send(1'b1);
      check("t5_b2_out", out_a, 1'b0);
      check("t5_b2_state", state_a, 2'b01);
      send(1'b1);
      check("t5_b3_out", out_a, 1'b1);
      check("t5_b3_state", state_a, 2'b10);

      // 6: reset mid-pattern
      do_load(8'h07, 4'd3, 1'b1);
      send(1'b1);
      send(1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("t6_state", state_a, 2'b00);
      check("t6_out", out_a, 1'b0);
      check("t6_cnt", cnt_a, 8'd0);
      check("t6_sat", sat_a, 1'b0);
      check("t6_cnt_b", cnt_b, 2'd0);
      for (int k = 0; k < 4; k++) begin
         send(1'b1);
         check($sformatf("t6_out%0d", k), out_a, 1'b0);
         check($sformatf("t6_idle%0d", k), state_a, 2'b00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
